// File: rtl/ahb_avalon_pkg.sv
// Shared types and constants for the AHB-Lite slave to Avalon-MM master bridge.
//
// Contents:
//   state_t             bridge FSM state encoding
//   Htrans*/Hresp*/Hsize* AHB field encodings
//   size_to_byteenable  HSIZE + HADDR[1:0] -> Avalon byte lanes
//   is_illegal          size/alignment legality check for the ERROR response
//
// Build option: AHB_AVALON_ERR_RESP_EN adds the ERROR response states.
package ahb_avalon_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWr     = 3'd1,
        StRdCmd  = 3'd2,
        StRdWait = 3'd3
`ifdef AHB_AVALON_ERR_RESP_EN
        ,
        StErr1   = 3'd4,
        StErr2   = 3'd5
`endif
    } state_t;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [1:0] HrespOkay  = 2'b00;
    localparam logic [1:0] HrespError = 2'b01;

    localparam logic [2:0] HsizeByte = 3'b000;
    localparam logic [2:0] HsizeHalf = 3'b001;
    localparam logic [2:0] HsizeWord = 3'b010;

    // Sizes above a word fall into the default arm and enable all four lanes.
    function automatic logic [3:0] size_to_byteenable(input logic [2:0] hsize,
                                                      input logic [1:0] addr_lo);
        logic [3:0] be;
        case (hsize)
            HsizeByte: be = 4'b0001 << addr_lo;
            HsizeHalf: be = 4'b0011 << {addr_lo[1], 1'b0};
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_illegal(input logic [2:0] hsize, input logic [1:0] addr_lo);
        return (hsize > HsizeWord) ||
               ((hsize == HsizeHalf) && addr_lo[0]) ||
               ((hsize == HsizeWord) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_addr_phase_reg.sv
// AHB address-phase capture: decides whether the current address phase is
// accepted and holds the sampled address/control for the following data phase.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   hsel_i .. hreadyin_i AHB address-phase inputs
//   hreadyout_i          bridge's own HREADYOUT (phase may only advance when high)
//   accept_o             a NONSEQ/SEQ transfer is taken at the next rising edge
//   req_write_o          HWRITE of the transfer being accepted
//   req_illegal_o        legality flag of the transfer being accepted
//   addr_o, write_o,
//   be_o, illegal_o      registered address-phase information
//
// Build option: AHB_AVALON_ERR_RESP_EN enables the legality check; without it
// req_illegal_o is 0 and illegal sizes map to a full word.
module ahb_addr_phase_reg
    import ahb_avalon_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 hsel_i,
    input  logic [AddrWidth-1:0] haddr_i,
    input  logic [1:0]           htrans_i,
    input  logic                 hwrite_i,
    input  logic [2:0]           hsize_i,
    input  logic                 hreadyin_i,
    input  logic                 hreadyout_i,
    output logic                 accept_o,
    output logic                 req_write_o,
    output logic                 req_illegal_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 write_o,
    output logic [3:0]           be_o,
    output logic                 illegal_o
);

    logic [AddrWidth-1:0] addr_q;
    logic                 write_q;
    logic [3:0]           be_q;
    logic                 illegal_q;
    logic                 illegal_now;

    assign accept_o = hsel_i & hreadyin_i & hreadyout_i &
                      ((htrans_i == HtransNonseq) || (htrans_i == HtransSeq));

`ifdef AHB_AVALON_ERR_RESP_EN
    assign illegal_now = is_illegal(hsize_i, haddr_i[1:0]);
`else
    assign illegal_now = 1'b0;
`endif

    assign req_write_o   = hwrite_i;
    assign req_illegal_o = illegal_now;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            be_q      <= 4'b0000;
            illegal_q <= 1'b0;
        end else if (accept_o) begin
            addr_q    <= {haddr_i[AddrWidth-1:2], 2'b00};
            write_q   <= hwrite_i;
            be_q      <= size_to_byteenable(hsize_i, haddr_i[1:0]);
            illegal_q <= illegal_now;
        end
    end

    assign addr_o    = addr_q;
    assign write_o   = write_q;
    assign be_o      = be_q;
    assign illegal_o = illegal_q;

endmodule

// File: rtl/ahb_avalon_bridge.sv
// AHB-Lite slave to Avalon-MM master bridge. Each accepted NONSEQ/SEQ transfer
// becomes one Avalon read or write; the AHB data phase is stretched with
// HREADYOUT until the Avalon side completes. One transfer outstanding.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   HSEL..HREADYIN                   AHB-Lite slave inputs
//   HRDATA, HREADYOUT, HRESP         AHB-Lite slave outputs
//   avm_address..avm_byteenable      Avalon-MM master command outputs
//   avm_waitrequest, avm_readdata,
//   avm_readdatavalid                Avalon-MM master response inputs
//
// Build option: AHB_AVALON_ERR_RESP_EN returns a two-cycle ERROR for illegal
// size/alignment instead of issuing an Avalon access.
module ahb_avalon_bridge
    import ahb_avalon_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = 32,
    parameter int unsigned DATAWIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    HSEL,
    input  logic [ADDRESSWIDTH-1:0] HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [DATAWIDTH-1:0]    HWDATA,
    input  logic                    HREADYIN,
    output logic [DATAWIDTH-1:0]    HRDATA,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    output logic [ADDRESSWIDTH-1:0] avm_address,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATAWIDTH-1:0]    avm_writedata,
    output logic [3:0]              avm_byteenable,
    input  logic                    avm_waitrequest,
    input  logic [DATAWIDTH-1:0]    avm_readdata,
    input  logic                    avm_readdatavalid
);

`ifdef AHB_AVALON_ERR_RESP_EN
    localparam state_t ErrEntry = StErr1;
`else
    // Never reached: the legality flag is tied low in this build.
    localparam state_t ErrEntry = StIdle;
`endif

    state_t                  state_q, state_d, dispatch;
    logic                    accept, req_write, req_illegal;
    logic                    write_q, illegal_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [3:0]              be_q;

    ahb_addr_phase_reg #(
        .AddrWidth (ADDRESSWIDTH)
    ) u_addr_phase (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .hsel_i        (HSEL),
        .haddr_i       (HADDR),
        .htrans_i      (HTRANS),
        .hwrite_i      (HWRITE),
        .hsize_i       (HSIZE),
        .hreadyin_i    (HREADYIN),
        .hreadyout_i   (HREADYOUT),
        .accept_o      (accept),
        .req_write_o   (req_write),
        .req_illegal_o (req_illegal),
        .addr_o        (addr_q),
        .write_o       (write_q),
        .be_o          (be_q),
        .illegal_o     (illegal_q)
    );

    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;

    // Output decode. HREADYOUT follows the Avalon handshake combinationally so a
    // completing cycle can also take the pipelined next address phase.
    always_comb begin
        HREADYOUT     = 1'b1;
        HRESP         = HrespOkay;
        HRDATA        = '0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        case (state_q)
            StWr: begin
                avm_write     = write_q & ~illegal_q;
                avm_writedata = HWDATA;
                HREADYOUT     = ~avm_waitrequest;
            end
            StRdCmd: begin
                avm_read  = ~write_q & ~illegal_q;
                HREADYOUT = 1'b0;
            end
            StRdWait: begin
                HRDATA    = avm_readdata;
                HREADYOUT = avm_readdatavalid;
            end
`ifdef AHB_AVALON_ERR_RESP_EN
            StErr1: begin
                HRESP     = HrespError;
                HREADYOUT = 1'b0;
            end
            StErr2: begin
                HRESP = HrespError;
            end
`endif
            default: ;
        endcase
    end

    // Destination for whatever address phase is being sampled this cycle.
    always_comb begin
        dispatch = StIdle;
        if (accept) begin
            if (req_illegal) begin
                dispatch = ErrEntry;
            end else if (req_write) begin
                dispatch = StWr;
            end else begin
                dispatch = StRdCmd;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = dispatch;
            StWr:     if (!avm_waitrequest) state_d = dispatch;
            StRdCmd:  if (!avm_waitrequest) state_d = StRdWait;
            StRdWait: if (avm_readdatavalid) state_d = dispatch;
`ifdef AHB_AVALON_ERR_RESP_EN
            StErr1:   state_d = StErr2;
            StErr2:   state_d = dispatch;
`endif
            default:  state_d = StIdle;
        endcase
    end

    // Reset drops any in-flight transfer; a late readdatavalid then lands in
    // IDLE, which does not look at it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/ahb_avalon_bridge.md
Name: ahb_avalon_bridge

Overview:
- AHB-Lite slave to Avalon-MM master bridge. It is the counterpart of the existing Avalon-to-AHB bridge: it lets an AHB master (CPU/DMA) reach Qsys Avalon slaves.
- Converts each AHB NONSEQ/SEQ transfer into one Avalon read or write.
- Stretches the AHB data phase with HREADYOUT until the Avalon side completes.
- Single outstanding transfer; no bursts on the Avalon side.

Parameters:
- ADDRESSWIDTH, 32, width of HADDR and avm_address (both are byte addresses).
- DATAWIDTH, 32, data bus width; only 32 is supported.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- HSEL  input  1  slave select
- HADDR  input  ADDRESSWIDTH  AHB byte address
- HTRANS  input  2  transfer type
- HWRITE  input  1  1 = write
- HSIZE  input  3  transfer size
- HWDATA  input  DATAWIDTH  write data, valid in data phase
- HREADYIN  input  1  bus ready, from the interconnect
- HRDATA  output  DATAWIDTH  read data
- HREADYOUT  output  1  data-phase complete
- HRESP  output  2  00 OKAY, 01 ERROR
- avm_address  output  ADDRESSWIDTH  Avalon byte address, word-aligned
- avm_read  output  1  Avalon read request
- avm_write  output  1  Avalon write request
- avm_writedata  output  DATAWIDTH  Avalon write data
- avm_byteenable  output  4  Avalon byte lanes
- avm_waitrequest  input  1  Avalon stall
- avm_readdata  input  DATAWIDTH  Avalon read data
- avm_readdatavalid  input  1  Avalon read data valid

Interface decision (fixed): one clock, clk; reset_n is synchronous and active-low.

Behaviour:
- Address-phase sample: accept = HSEL & HREADYIN & HTRANS[1] at a rising edge where HREADYOUT=1.
  - On accept, register address, HWRITE, byteenable and the size-legality flag.
  - IDLE/BUSY transfers get a zero-wait OKAY.
- Byte enables, by HSIZE and HADDR[1:0]:
  - byte: 0001 << HADDR[1:0]
  - halfword: 0011 << {HADDR[1],0}
  - word: 1111
- avm_address = {HADDR[ADDRESSWIDTH-1:2], 2'b00}.
- States: IDLE, WR, RD_CMD, RD_WAIT, ERR1, ERR2.
- IDLE:
  - HREADYOUT=1, HRESP=00.
  - accept & write goes to WR; accept & read goes to RD_CMD.
- WR:
  - avm_write=1, avm_writedata=HWDATA (held stable by the master while HREADYOUT=0).
  - HREADYOUT = ~avm_waitrequest.
  - On the completing edge, the pipelined next address phase is sampled in the same cycle, so back-to-back transfers carry no idle cycle.
- RD_CMD:
  - avm_read=1, HREADYOUT=0.
  - Goes to RD_WAIT on the edge where avm_waitrequest=0.
- RD_WAIT:
  - avm_read=0.
  - HRDATA = avm_readdata; HREADYOUT = avm_readdatavalid.
  - On readdatavalid, the next transfer is sampled; otherwise go to IDLE.
- Minimum latency:
  - write: 1 data-phase cycle.
  - read: 2 data-phase cycles (the Avalon pipelined read gives readdatavalid no earlier than one cycle after acceptance).
- HRDATA is 0 outside RD_WAIT.
- Reset values of all outputs:
  - HREADYOUT=1, HRESP=00, HRDATA=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0.
- Reset mid-transfer: return to IDLE immediately and drop avm_read/avm_write. A late readdatavalid is ignored; it must not complete a new transfer.
- avm_read and avm_write are never both high.
- avm_address and avm_byteenable stay stable while avm_waitrequest=1.

Optional Feature:
- Macro: AHB_AVALON_ERR_RESP_EN.
- When defined, an illegal transfer produces the AHB two-cycle ERROR response and no Avalon access:
  - Illegal means HSIZE > 3'b010, or a misaligned address (half: HADDR[0]=1; word: HADDR[1:0]!=0).
  - ERR1: HRESP=01, HREADYOUT=0.
  - ERR2: HRESP=01, HREADYOUT=1; the next address is sampled here.
- When undefined:
  - HRESP is tied to 00 and the ERR states are absent.
  - An illegal size is treated as word (byteenable 1111).
  - The address is forced word-aligned.

Decomposition:
- Package ahb_avalon_pkg holds:
  - state_t enum.
  - HTRANS constants (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP constants (OKAY/ERROR).
  - HSIZE constants.
  - function size_to_byteenable(hsize, addr_lo).
- Sub-module ahb_addr_phase_reg holds the sampled address/control registers and the accept logic.
- The FSM and output decode stay in the top.

Test Plan:
- Single write, no wait:
  - Stimulus: NONSEQ write HADDR=0x0000_0010, HWDATA=0xDEADBEEF, avm_waitrequest=0.
  - Required: avm_write=1 for exactly 1 cycle with address 0x10, be 1111, data 0xDEADBEEF; HREADYOUT low for 0 cycles.
- Write with 3 waitrequest cycles:
  - Required: HREADYOUT=0 for 3 cycles; avm_write/avm_address stable; completes on the 4th cycle.
- Read:
  - Stimulus: HADDR=0x24; readdatavalid 2 cycles after acceptance with data 0x12345678.
  - Required: HRDATA=0x12345678 with HREADYOUT=1 in the same cycle; avm_read high exactly 1 cycle.
- Back-to-back write 0x0 then read 0x4:
  - Required: the read address is sampled on the write-completion edge; avm_read asserts the next cycle; no IDLE gap.
- Byte write HSIZE=000 to HADDR=0x7:
  - Required: avm_byteenable=1000, avm_address=0x4.
- With AHB_AVALON_ERR_RESP_EN:
  - Stimulus: word read at HADDR=0x2.
  - Required: HRESP=01 with HREADYOUT=0 then 1, avm_read never asserted.
- Reset mid-transfer: assert reset_n=0 during RD_WAIT.
  - Required: next cycle IDLE, HREADYOUT=1, a late readdatavalid is ignored.
